// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, data-side and memory-side handshake signals of mem_arbiter.
// master: the arbiter itself; slave: the core stages plus the memory.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   logic          busy;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, busy
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the MIPS fetch and memory stages; one access per 3+ cycles.
// Data side wins by default; define MEM_ARB_RR_EN for round-robin between the two sides.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.master bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] IF_ACC = 2'd1;
   localparam logic [1:0] DM_ACC = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]    state;
   logic [1:0]    stateNext;
   logic [AW-1:0] holdAddr;
   logic          holdWe;
   logic [DW-1:0] holdWdata;
   logic          servingDm;
   logic [DW-1:0] ifRdata;
   logic [DW-1:0] dmRdata;
   logic          grantDm;
   logic          grantIf;
   logic          inAccess;

`ifdef MEM_ARB_RR_EN
   logic lastGrantDm;

   // Contested grants go to whichever side did not win last time.
   always_comb begin
      grantDm = bus.dm_req && (!bus.if_req || !lastGrantDm);
      grantIf = bus.if_req && !grantDm;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastGrantDm <= 1'b0;
      end else if (state == IDLE && (grantDm || grantIf)) begin
         lastGrantDm <= grantDm;
      end
   end
`else
   always_comb begin
      grantDm = bus.dm_req;
      grantIf = bus.if_req && !bus.dm_req;
   end
`endif

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (grantDm) begin
               stateNext = DM_ACC;
            end else if (grantIf) begin
               stateNext = IF_ACC;
            end
         end
         IF_ACC, DM_ACC: begin
            if (bus.mem_ack) begin
               stateNext = DONE;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         holdAddr  <= '0;
         holdWe    <= 1'b0;
         holdWdata <= '0;
         servingDm <= 1'b0;
         ifRdata   <= '0;
         dmRdata   <= '0;
      end else begin
         state <= stateNext;
         // Requester inputs are only looked at here; the access runs off the holding copies.
         if (state == IDLE && (grantDm || grantIf)) begin
            servingDm <= grantDm;
            holdAddr  <= grantDm ? bus.dm_addr : bus.if_addr;
            holdWe    <= grantDm && bus.dm_we;
            holdWdata <= grantDm ? bus.dm_wdata : '0;
         end
         if (state == IF_ACC && bus.mem_ack) begin
            ifRdata <= bus.mem_rdata;
         end
         if (state == DM_ACC && bus.mem_ack && !holdWe) begin
            dmRdata <= bus.mem_rdata;
         end
      end
   end

   assign inAccess      = (state == IF_ACC) || (state == DM_ACC);
   assign bus.mem_req   = inAccess;
   assign bus.mem_we    = inAccess && holdWe;
   assign bus.mem_addr  = holdAddr;
   assign bus.mem_wdata = holdWdata;
   assign bus.busy      = (state != IDLE);
   assign bus.if_ready  = (state == DONE) && !servingDm;
   assign bus.dm_ready  = (state == DONE) && servingDm;
   assign bus.if_rdata  = ifRdata;
   assign bus.dm_rdata  = dmRdata;

   assert property (@(posedge clk) disable iff (!reset) !(bus.if_ready && bus.dm_ready));
   assert property (@(posedge clk) disable iff (!reset) (state == DONE) |=> (state == IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters and a variable-latency memory model drive the DUT,
// expected grants and read data are queued at issue/grant time and popped when ready strobes appear.
module tb_mem_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();
   mem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MEM_ARB_RR_EN
   localparam int ROUNDS = 2;
`else
   localparam int ROUNDS = 1;
`endif

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t        ifReqQ[$];
   req_t        dmReqQ[$];
   logic [31:0] ifRespQ[$];
   logic [31:0] dmRespQ[$];
   logic [31:0] memModel[logic [31:0]];
   bit          grantLog[$];

   int   checks = 0;
   int   passes = 0;
   bit   ifBusy, dmBusy, ifGranted, dmGranted;
   bit   scramble = 1'b0;
   bit   forceAck = 1'b0;
   int   ackLatency = 1;
   bit   ifAtEdge, dmAtEdge, modelLastDm;
   logic [31:0] lastDmRdata;
   int   ifReadyCnt = 0;
   int   dmReadyCnt = 0;

   bit   inAccess = 1'b0;
   int   waitCnt = 0;
   int   phase = 0;
   req_t cur;
   bit   curDm;
   logic [31:0] curResp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   always @(posedge clk) begin
      ifAtEdge = bus.if_req;
      dmAtEdge = bus.dm_req;
   end

   // Memory model: decides which request should have been granted, supplies data, acks after a latency.
   always @(negedge clk) begin
      bus.mem_ack   = forceAck;
      bus.mem_rdata = $urandom;
      if (!reset) begin
         inAccess    = 1'b0;
         phase       = 0;
         modelLastDm = 1'b0;
         lastDmRdata = '0;
         ifGranted   = 1'b0;
         dmGranted   = 1'b0;
      end else if (phase == 2) begin
         check("done_ready", curDm ? bus.dm_ready : bus.if_ready, 1);
         check("done_no_req", bus.mem_req, 0);
         phase = 1;
      end else if (phase == 1) begin
         check("idle_gap", {bus.mem_req, bus.busy}, 0);
         phase = 0;
      end else begin
         if (bus.mem_req && !inAccess) begin
`ifdef MEM_ARB_RR_EN
            if (ifAtEdge && dmAtEdge) curDm = !modelLastDm;
            else curDm = dmAtEdge;
`else
            curDm = dmAtEdge;
`endif
            check("grant_has_request", ifAtEdge || dmAtEdge, 1);
            check("grant_queue", curDm ? (dmReqQ.size() != 0) : (ifReqQ.size() != 0), 1);
            if (curDm && dmReqQ.size() != 0) cur = dmReqQ.pop_front();
            else if (!curDm && ifReqQ.size() != 0) cur = ifReqQ.pop_front();
            else cur = '0;
            if (cur.we) begin
               memModel[cur.addr] = cur.wdata;
               curResp = lastDmRdata;
            end else begin
               if (!memModel.exists(cur.addr)) memModel[cur.addr] = $urandom;
               curResp = memModel[cur.addr];
               if (curDm) lastDmRdata = curResp;
            end
            if (curDm) begin
               dmRespQ.push_back(curResp);
               dmGranted = 1'b1;
            end else begin
               ifRespQ.push_back(curResp);
               ifGranted = 1'b1;
            end
            grantLog.push_back(curDm);
            modelLastDm = curDm;
            waitCnt  = (ackLatency > 0) ? ackLatency : int'($urandom_range(1, 4));
            inAccess = 1'b1;
         end
         if (inAccess) begin
            check("mem_req", bus.mem_req, 1);
            check("busy", bus.busy, 1);
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_we", bus.mem_we, cur.we);
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
            waitCnt--;
            if (waitCnt == 0) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = cur.we ? $urandom : curResp;
               inAccess      = 1'b0;
               phase         = 2;
            end
         end
      end
   end

   // Ready monitor: every strobe must match the oldest expected response of its side.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.if_ready || bus.dm_ready) check("single_ready", bus.if_ready && bus.dm_ready, 0);
         if (bus.if_ready) begin
            ifReadyCnt++;
            check("if_ready_expected", ifRespQ.size() != 0, 1);
            if (ifRespQ.size() != 0) check("if_rdata", bus.if_rdata, ifRespQ.pop_front());
         end
         if (bus.dm_ready) begin
            dmReadyCnt++;
            check("dm_ready_expected", dmRespQ.size() != 0, 1);
            if (dmRespQ.size() != 0) check("dm_rdata", bus.dm_rdata, dmRespQ.pop_front());
         end
      end
   end

   // Requester side: release on ready; in scramble mode disturb inputs and drop req after grant.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.if_ready) begin
            bus.if_req = 1'b0;
            ifBusy     = 1'b0;
            ifGranted  = 1'b0;
         end else if (scramble && ifGranted) begin
            bus.if_addr = $urandom;
            if ($urandom_range(0, 5) == 0) bus.if_req = 1'b0;
         end
         if (bus.dm_ready) begin
            bus.dm_req = 1'b0;
            dmBusy     = 1'b0;
            dmGranted  = 1'b0;
         end else if (scramble && dmGranted) begin
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
            bus.dm_we    = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) bus.dm_req = 1'b0;
         end
      end
   end

   task automatic issue(input bit dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      req_t r;
      int n = 0;
      while ((dm ? dmBusy : ifBusy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("issue_wait", dm ? dmBusy : ifBusy, 0);
      r.we    = dm ? we : 1'b0;
      r.addr  = addr;
      r.wdata = dm ? wdata : 32'h0;
      if (dm) begin
         bus.dm_req   = 1'b1;
         bus.dm_we    = we;
         bus.dm_addr  = addr;
         bus.dm_wdata = wdata;
         dmReqQ.push_back(r);
         dmBusy = 1'b1;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
         ifReqQ.push_back(r);
         ifBusy = 1'b1;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((ifBusy || dmBusy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, ifBusy || dmBusy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic waitFor(input string name, input bit dmReady, input bit memReq, output int n, output int hi);
      n  = 0;
      hi = 0;
      while (!(memReq ? bus.mem_req : (dmReady ? bus.dm_ready : bus.if_ready)) && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.mem_req) hi++;
      end
      check(name, memReq ? bus.mem_req : (dmReady ? bus.dm_ready : bus.if_ready), 1);
   endtask

   initial begin
      int n, hi, cnt0;
      logic [31:0] prevRd;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_if_ready", bus.if_ready, 0);
      check("rst_dm_ready", bus.dm_ready, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_dm_rdata", bus.dm_rdata, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b1;
      @(negedge clk);

      // Fetch only, single-cycle memory
      memModel[32'h40] = 32'h8C220004;
      ackLatency = 1;
      issue(0, 0, 32'h40, 0);
      waitFor("fetch_ready_seen", 0, 0, n, hi);
      check("fetch_latency", n, 2);
      check("fetch_rdata", bus.if_rdata, 32'h8C220004);
      @(negedge clk);
      check("fetch_strobe_width", bus.if_ready, 0);
      drain("fetch_drain");

      // Store, 3-cycle memory
      ackLatency = 3;
      prevRd = bus.dm_rdata;
      issue(1, 1, 32'h100, 32'hDEADBEEF);
      waitFor("store_ready_seen", 1, 0, n, hi);
      check("store_req_cycles", hi, 3);
      check("store_latency", n, 4);
      check("store_rdata_kept", bus.dm_rdata, prevRd);
      drain("store_drain");

      // Address stability: requester moves to 0x44 during the fetch of 0x40
      ackLatency = 4;
      issue(0, 0, 32'h40, 0);
      @(negedge clk);
      bus.if_addr = 32'h44;
      waitFor("stable_ready_seen", 0, 0, n, hi);
      check("stable_rdata", bus.if_rdata, 32'h8C220004);
      drain("stable_drain");

      // Contention from a clean reset
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      grantLog.delete();
      ackLatency = 2;
      issue(1, 0, 32'h200, 0);
      issue(0, 0, 32'h300, 0);
      fork
         begin
            for (int k = 1; k < ROUNDS; k++) issue(1, 0, 32'h200 + 32'(4 * k), 0);
         end
         begin
            for (int k = 1; k < ROUNDS; k++) issue(0, 0, 32'h300 + 32'(4 * k), 0);
         end
      join
      drain("contention_drain");
      check("contention_grants", grantLog.size(), 2 * ROUNDS);
      for (int i = 0; i < grantLog.size(); i++)
         check($sformatf("contention_grant%0d", i), grantLog[i], (i % 2) == 0);

      // Reset in the middle of a data access
      ackLatency = 4;
      issue(1, 0, 32'h400, 0);
      waitFor("rst_mid_started", 0, 1, n, hi);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_mem_req", bus.mem_req, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_dm_ready", bus.dm_ready, 0);
      check("rst_mid_mem_addr", bus.mem_addr, 0);
      bus.dm_req = 1'b0;
      dmBusy = 1'b0;
      dmReqQ.delete();
      dmRespQ.delete();
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      cnt0 = ifReadyCnt + dmReadyCnt;
      forceAck = 1'b1;
      repeat (3) @(negedge clk);
      #2 forceAck = 1'b0;
      repeat (3) @(negedge clk);
      check("late_ack_no_ready", ifReadyCnt + dmReadyCnt, cnt0);
      check("late_ack_idle", bus.busy, 0);

      // Data request dropped mid-access
      ackLatency = 3;
      cnt0 = dmReadyCnt;
      issue(1, 0, 32'h500, 0);
      waitFor("drop_started", 0, 1, n, hi);
      bus.dm_req = 1'b0;
      waitFor("drop_ready_seen", 1, 0, n, hi);
      drain("drop_drain");
      check("drop_single_strobe", dmReadyCnt - cnt0, 1);

      // Randomized traffic from both sides
      scramble   = 1'b1;
      ackLatency = 0;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               issue(0, 0, 32'h1000 + ($urandom_range(0, 15) << 2), 0);
            end
         end
         begin
            for (int k = 0; k < 40; k++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               issue(1, 1'($urandom_range(0, 1)), 32'h1000 + ($urandom_range(0, 15) << 2), $urandom);
            end
         end
      join
      drain("random_drain");
      check("queues_empty", ifRespQ.size() + dmRespQ.size() + ifReqQ.size() + dmReqQ.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the fetch stage and the memory stage of the pipelined MIPS core. It serializes requests from both stages, drives a variable-latency req/ack memory port, and returns per-requester ready strobes. The data-side ready is the core's MemReady, which the hazard unit uses for stalling. The fetch-side ready gates the IF-stage stall.

## Interface
- AW, 32, address width in bits
- DW, 32, data width in bits

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  AW  fetch byte address
- if_rdata  out  DW  fetched word; valid while if_ready=1
- if_ready  out  1  one-cycle fetch completion strobe
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data byte address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data; valid while dm_ready=1
- dm_ready  out  1  one-cycle data completion strobe (MemReady)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; any latency ≥1 cycle after mem_req
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, IF_ACC, DM_ACC, DONE.
- **IDLE**
  - Samples if_req and dm_req.
  - On a grant, latches addr, we and wdata into holding registers.
  - Moves to IF_ACC or DM_ACC.
  - With no request, stays in IDLE.
- **IF_ACC / DM_ACC**
  - mem_req=1.
  - mem_addr, mem_we and mem_wdata are driven from the holding registers and stay stable until ack.
  - mem_we is 0 for fetch.
  - On mem_ack=1: latches mem_rdata into if_rdata or dm_rdata, then goes to DONE.
  - For stores, dm_rdata keeps its previous value.
- **DONE**
  - Pulses if_ready or dm_ready for exactly one cycle, whichever matches the completed access.
  - mem_req=0.
  - Requests are not sampled in DONE; the next state is always IDLE.
- **Arbitration:** fixed priority, data over fetch, because the memory stage is older.
- **Requester drops req mid-access:** the access still completes and the ready strobe is still issued; there is no abort.
- **Changing addr/data mid-access:** ignored, since the holding registers are used.
- **if_rdata / dm_rdata:** hold their last value between strobes.

## Timing
- **Reset values:** state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, busy=0.
- **Reset asserted mid-access:** the access is abandoned immediately and all outputs take their reset values. A late mem_ack is ignored once in IDLE.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- **Minimum latency:** req sampled at edge N → mem_req high in cycle N+1 → mem_ack sampled at edge N+1 → ready in cycle N+2.
- **Memory latency L:** ready comes L+1 cycles after grant.
- **Throughput:** at most one access per 3 cycles, because IDLE and DONE are separate states.
- mem_ack is ignored outside IF_ACC/DM_ACC.

## Configuration
- **MEM_ARB_RR_EN defined:** round-robin arbitration.
  - A last_grant flip-flop records the side granted most recently.
  - When both requests are pending in IDLE, the side not in last_grant is granted.
  - last_grant resets to IF, so the first contested grant goes to DM.
  - A single pending request is granted regardless of last_grant.
- **MEM_ARB_RR_EN undefined:** fixed data-over-fetch priority, and the last_grant register is not built.

## Test plan
- **Fetch only:** if_req=1, if_addr=0x40, mem_ack one cycle after mem_req with mem_rdata=0x8C220004 → mem_addr=0x40, mem_we=0, if_ready pulses for 1 cycle, 2 cycles after the request is sampled, with if_rdata=0x8C220004.
- **Store with 3-cycle memory latency:** dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_req high for 3 cycles, mem_we=1, mem_wdata=0xDEADBEEF, then one dm_ready pulse; dm_rdata unchanged.
- **Contention:** if_req and dm_req asserted together and held across several accesses.
  - Without the macro: DM is granted first, then IF, after the DONE/IDLE gap.
  - With MEM_ARB_RR_EN: grants strictly alternate DM, IF, DM, IF.
- **Address stability:** if_addr changed to 0x44 during an outstanding fetch of 0x40 → mem_addr stays 0x40 until mem_ack.
- **Reset mid-access:** reset driven low while in DM_ACC → mem_req=0, busy=0 and dm_ready=0 immediately, without waiting for clk. A later mem_ack=1 produces no ready strobe.
- **Dropped request:** dm_req deasserted while in DM_ACC → access completes and dm_ready still pulses once.
